// File: rtl/pack_fifo.sv
// pack_fifo: byte-in, word-out gathering FIFO. Elements go into a circular
// array and leave as one packed little-endian word of four elements. A flush
// zero-pads a trailing partial word so the tail of a stream can be drained.
module pack_fifo #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr,
  input  logic [DWIDTH-1:0]     w_data,
  input  logic                  flush,
  input  logic                  rd,
  output logic                  full,
  output logic                  empty,
  output logic [AWIDTH:0]       count,
  output logic [4*DWIDTH-1:0]   r_data,
  output logic                  r_valid
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;
  localparam int unsigned CW    = AWIDTH + 1;
  localparam int unsigned WW    = 4 * DWIDTH;

  logic [DWIDTH-1:0] array_reg [DEPTH];
  logic [AWIDTH-1:0] w_ptr;
  logic [AWIDTH-1:0] r_ptr;
  logic [CW-1:0]     count_reg;
  logic [WW-1:0]     r_data_reg;
  logic              r_valid_reg;

  logic              w_en;
  logic              f_en;
  logic              r_en;
  logic [CW-1:0]     pad;
  logic [AWIDTH-1:0] w_ptr_next;
  logic [CW-1:0]     count_next;
  logic [WW-1:0]     rd_word;

  // Flags derive directly from the registered element count
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg < CW'(4));
  assign count   = count_reg;
  assign r_data  = r_data_reg;
  assign r_valid = r_valid_reg;

  // Accept decisions, pad size, next write pointer and next count
  always_comb begin
    w_en       = wr & ~full;
    f_en       = flush & ~wr & (w_ptr[1:0] != 2'd0);
    r_en       = rd & ~empty;
    pad        = CW'(4) - CW'(w_ptr[1:0]);
    w_ptr_next = w_ptr;
    if (w_en) begin
      w_ptr_next = w_ptr + AWIDTH'(1);
    end else if (f_en) begin
      w_ptr_next = (w_ptr | AWIDTH'(3)) + AWIDTH'(1);
    end
    count_next = count_reg
               + (w_en ? CW'(1) : CW'(0))
               + (f_en ? pad    : CW'(0))
               - (r_en ? CW'(4) : CW'(0));
  end

  // Gather the four elements starting at the read pointer into one word
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rd_word[k*DWIDTH +: DWIDTH] = array_reg[r_ptr + AWIDTH'(k)];
    end
  end

  // Storage: single write, or zero-fill of the rest of the current word on flush
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_en && (AWIDTH'(i) == w_ptr)) begin
          array_reg[i] <= w_data;
        end else if (f_en && (AWIDTH'(i) >= w_ptr) && (AWIDTH'(i) <= (w_ptr | AWIDTH'(3)))) begin
          array_reg[i] <= '0;
        end
      end
    end
  end

  // Pointers, count and the registered read port
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count_reg   <= '0;
      r_data_reg  <= '0;
      r_valid_reg <= 1'b0;
    end else begin
      w_ptr       <= w_ptr_next;
      count_reg   <= count_next;
      r_valid_reg <= r_en;
      if (r_en) begin
        r_ptr      <= r_ptr + AWIDTH'(4);
        r_data_reg <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_pack_fifo.sv
// Bench for pack_fifo: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pack_fifo;

  localparam int unsigned DWIDTH = 8;
  localparam int unsigned AWIDTH = 4;
  localparam int unsigned DEPTH  = 16;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                wr = 1'b0;
  logic [DWIDTH-1:0]   w_data = '0;
  logic                flush = 1'b0;
  logic                rd = 1'b0;
  logic                full;
  logic                empty;
  logic [AWIDTH:0]     count;
  logic [4*DWIDTH-1:0] r_data;
  logic                r_valid;

  pack_fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .wr     (wr),
    .w_data (w_data),
    .flush  (flush),
    .rd     (rd),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .r_data (r_data),
    .r_valid(r_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: stored elements (pads included) as a plain queue
  logic [7:0]  q[$];
  int          wmod    = 0;
  logic [31:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;
  logic        chk_en  = 1'b0;

  task automatic model_edge(input logic i_wr, input logic [7:0] i_d,
                            input logic i_fl, input logic i_rd, input logic i_rn);
    int sz;
    logic m_full, m_empty;
    if (!i_rn) begin
      q.delete();
      wmod     = 0;
      m_rdata  = '0;
      m_rvalid = 1'b0;
      return;
    end
    sz      = q.size();
    m_full  = (sz == int'(DEPTH));
    m_empty = (sz < 4);
    m_rvalid = 1'b0;
    if (i_rd && !m_empty) begin
      m_rdata  = {q[3], q[2], q[1], q[0]};
      m_rvalid = 1'b1;
      for (int k = 0; k < 4; k++) void'(q.pop_front());
    end
    if (i_wr && !m_full) begin
      q.push_back(i_d);
      wmod = (wmod + 1) % 4;
    end else if (i_fl && !i_wr && wmod != 0) begin
      while (wmod != 0) begin
        q.push_back(8'h00);
        wmod = (wmod + 1) % 4;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("count",   32'(count),   32'(q.size()));
      cmp("full",    32'(full),    32'(q.size() == int'(DEPTH)));
      cmp("empty",   32'(empty),   32'(q.size() < 4));
      cmp("r_valid", 32'(r_valid), 32'(m_rvalid));
      cmp("r_data",  r_data,       m_rdata);
    end
  end

  task automatic step(input logic i_wr, input logic [7:0] i_d, input logic i_fl,
                      input logic i_rd, input logic i_rn);
    @(negedge clk);
    wr = i_wr; w_data = i_d; flush = i_fl; rd = i_rd; resetn = i_rn;
    @(posedge clk);
    model_edge(i_wr, i_d, i_fl, i_rd, i_rn);
    #1;
  endtask

  task automatic wr_b(input logic [7:0] d);  step(1'b1, d, 1'b0, 1'b0, 1'b1); endtask
  task automatic rd_w();                     step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1); endtask
  task automatic fl();                       step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); endtask
  task automatic rst();                      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

  initial begin
    // Reset state
    rst();
    chk_en = 1'b1;
    rst();
    cmp("rst_count", 32'(count), 32'd0);
    cmp("rst_empty", 32'(empty), 32'd1);
    cmp("rst_full",  32'(full),  32'd0);
    cmp("rst_rvld",  32'(r_valid), 32'd0);
    cmp("rst_rdata", r_data, 32'd0);

    // Reset then pack
    wr_b(8'h11); wr_b(8'h22); wr_b(8'h33);
    cmp("pack_empty3", 32'(empty), 32'd1);
    wr_b(8'h44);
    cmp("pack_empty4", 32'(empty), 32'd0);
    rd_w();
    cmp("pack_rdata", r_data, 32'h44332211);
    cmp("pack_rvld",  32'(r_valid), 32'd1);
    cmp("pack_count", 32'(count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cmp("pack_rvld_pulse", 32'(r_valid), 32'd0);
    cmp("pack_hold", r_data, 32'h44332211);

    // Fill to full, drop extra write, pop four words
    for (int i = 0; i < 16; i++) wr_b(8'(i));
    cmp("fill_full", 32'(full), 32'd1);
    cmp("fill_count", 32'(count), 32'd16);
    wr_b(8'hAA);
    cmp("fill_drop_count", 32'(count), 32'd16);
    rd_w(); cmp("fill_w0", r_data, 32'h03020100);
    rd_w(); cmp("fill_w1", r_data, 32'h07060504);
    rd_w(); cmp("fill_w2", r_data, 32'h0B0A0908);
    rd_w(); cmp("fill_w3", r_data, 32'h0F0E0D0C);
    cmp("fill_empty", 32'(empty), 32'd1);

    // Flush pads a partial word; a second flush when aligned does nothing
    wr_b(8'hA1); wr_b(8'hA2);
    cmp("fl_count2", 32'(count), 32'd2);
    fl();
    cmp("fl_count4", 32'(count), 32'd4);
    fl();
    cmp("fl_again", 32'(count), 32'd4);
    rd_w();
    cmp("fl_rdata", r_data, 32'h0000A2A1);

    // Simultaneous rd and wr with count=5
    for (int i = 0; i < 5; i++) wr_b(8'h50 + 8'(i));
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    cmp("rw_count", 32'(count), 32'd2);
    cmp("rw_rvld",  32'(r_valid), 32'd1);
    cmp("rw_rdata", r_data, 32'h53525150);
    step(1'b1, 8'h66, 1'b1, 1'b0, 1'b1);
    cmp("fl_with_wr", 32'(count), 32'd3);
    fl(); rd_w();
    cmp("rw_tail", r_data, 32'h00665554);

    // Full with rd and wr: read taken, write dropped
    for (int i = 0; i < 16; i++) wr_b(8'h80 + 8'(i));
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    cmp("frw_count", 32'(count), 32'd12);
    cmp("frw_full",  32'(full), 32'd0);
    rd_w(); rd_w(); rd_w();
    cmp("frw_last", r_data, 32'h8F8E8D8C);

    // Randomized traffic including wraps and occasional mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom),
           1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 99) < 25),
           1'($urandom_range(0, 199) != 0));
    end

    // Mid-reset with count=6 discards everything
    rst();
    for (int i = 0; i < 6; i++) wr_b(8'hB0 + 8'(i));
    cmp("mr_count6", 32'(count), 32'd6);
    rst();
    cmp("mr_count", 32'(count), 32'd0);
    cmp("mr_empty", 32'(empty), 32'd1);
    cmp("mr_rvld",  32'(r_valid), 32'd0);
    cmp("mr_rdata", r_data, 32'd0);
    wr_b(8'hC1); wr_b(8'hC2); wr_b(8'hC3); wr_b(8'hC4);
    rd_w();
    cmp("mr_new", r_data, 32'hC4C3C2C1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pack_fifo.md
# pack_fifo

Byte-in, word-out gathering FIFO; the write-side counterpart of the accelerator's word-in/byte-out unpacking FIFO. Accepts one DWIDTH-bit element per cycle, typically a PE result byte, and stores it in a circular array. It delivers 4 elements at a time as one packed 4*DWIDTH-bit word toward the output/memory write path. A flush input zero-pads a trailing partial word so the tail of a result stream can be drained.

## Interface
- DWIDTH, 8, element width in bits
- AWIDTH, 4, log2 of storage depth in elements; must be >= 2, so depth 2**AWIDTH is a multiple of 4
- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  synchronous, active-low reset, sampled on rising edge of clk
- wr  in  1  write request for w_data
- w_data  in  DWIDTH  element to store
- flush  in  1  pad the current partial word with zeros
- rd  in  1  request to pop one packed word
- full  out  1  no element slot free
- empty  out  1  fewer than 4 elements stored, so no complete word is available
- count  out  AWIDTH+1  number of stored elements, including pad elements
- r_data  out  4*DWIDTH  last popped word, registered
- r_valid  out  1  r_data updated this cycle; single-cycle pulse

## Operation
- State:
  - array_reg[0..2**AWIDTH-1]
  - w_ptr and r_ptr, each AWIDTH bits, wrapping modulo depth
  - count_reg, AWIDTH+1 bits
  - r_data_reg and r_valid_reg
- Flags are combinational from count_reg:
  - full = (count_reg == 2**AWIDTH)
  - empty = (count_reg < 4)
- Write accept: w_en = wr & ~full.
  - array_reg[w_ptr] <= w_data.
  - w_ptr += 1 and count += 1.
  - A write while full is dropped with no state change.
- Flush accept: f_en = flush & ~wr & (w_ptr[1:0] != 0).
  - Writes zero to slots w_ptr .. (w_ptr | 3), all in one cycle.
  - w_ptr advances to the next multiple of 4; count rises by 4 - w_ptr[1:0].
  - Flush asserted together with wr is ignored that cycle; the write is taken.
  - Flush on an aligned w_ptr is a no-op.
  - Flush never overflows, because depth is a multiple of 4.
- Read accept: r_en = rd & ~empty.
  - Packed word, little-endian: r_data[DWIDTH-1:0] = array_reg[r_ptr], up to r_data[4*DWIDTH-1:3*DWIDTH] = array_reg[r_ptr+3].
  - r_ptr += 4, so r_ptr[1:0] is always 0.
  - count -= 4.
  - A read while empty is ignored and r_valid stays 0.
- Simultaneous accepted events: count_next = count + (w_en ? 1 : 0) + (f_en ? pad : 0) - (r_en ? 4 : 0).
- Read and write/flush slots never collide: a read consumes only completed slots.
- Enables use the registered full/empty at the start of the cycle. Example: with full=1, rd=1 and wr=1, the read is taken, the write is dropped, and full is 0 the next cycle.
- Pointer wrap: natural AWIDTH-bit overflow. The word at r_ptr = depth-4 is followed by r_ptr = 0.

## Timing
- Reset (resetn=0 at a rising edge):
  - w_ptr=0, r_ptr=0, count=0
  - full=0, empty=1
  - r_data=0, r_valid=0
  - Array contents unchanged.
- Reset asserted mid-stream discards all stored elements and any pending pad on that edge.
- Write-to-flag latency: count, full and empty reflect an accepted write or flush on the cycle after the edge that accepted it.
- Read latency: rd sampled at edge N gives r_valid=1 and the new r_data after edge N, i.e. during cycle N+1.
- r_data holds its value until the next accepted read.
- r_valid is high exactly one cycle per accepted read.
- Throughput: back-to-back reads are allowed every cycle while count >= 4. Sustained steady state is 1 element in and 1/4 word out per cycle.

## Test plan
- Reset then pack:
  - Stimulus: write 0x11, 0x22, 0x33, 0x44; empty must stay 1 until after the 4th write; then rd.
  - Required: r_data=0x44332211, r_valid one cycle, count=0, empty=1.
- Fill to full (AWIDTH=4):
  - Stimulus: 16 writes of 0x00..0x0F, then a 17th write of 0xAA; then pop 4 words.
  - Required: full=1 and count=16; 0xAA is dropped. Words are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
- Flush:
  - Stimulus: write 0xA1, 0xA2, then flush=1 for one cycle; then rd.
  - Required: count goes 2 to 4; r_data=0x0000A2A1.
  - Second flush right after (pointer now aligned): count unchanged.
- Simultaneous rd and wr:
  - Stimulus: count=5, rd=1 and wr=1 together.
  - Required: count=2 next cycle, r_valid=1.
- Full with rd and wr:
  - Stimulus: full, rd=1 and wr=1 together.
  - Required: count=12, write dropped.
- Wrap and mid-reset:
  - Stimulus: stream 40 bytes with interleaved reads; then resetn=0 for one edge with count=6.
  - Required: data order is preserved across 2 wraps. After reset: count=0, empty=1, r_valid=0, r_data=0, and a subsequent 4-write/1-read returns the new bytes only.
